// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock,
// LSB first. Busy is high while adding, Done pulses for one cycle with the result.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_reg;
  logic             carry;
  logic             cout_reg;
  logic [CNT_W-1:0] cnt;
  logic             sum_bit;
  logic             carry_nxt;
  logic             last_bit;
  logic             accept;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_reg;
`endif

  // Full-add of the current LSBs, last-bit detect and Start acceptance
  always_comb begin
    sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    last_bit  = (cnt == CNT_W'(WIDTH - 1));
    accept    = Start && ((state == IDLE) || (state == DONE));
  end

  // Next-state logic; Start is only honoured in IDLE and DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = ADD;
      ADD:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = Start ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath: operand load on accept, one shift/add step per ADD cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_sr     <= '0;
      b_sr     <= '0;
      s_reg    <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      cnt      <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg  <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B;
      carry <= Cin;
      cnt   <= '0;
    end else if (state == ADD) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_reg <= {sum_bit, s_reg[WIDTH-1:1]};
      carry <= carry_nxt;
      cnt   <= cnt + 1'b1;
      if (last_bit) begin
        cout_reg <= carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
        // carry holds the carry into bit WIDTH-1 during the last step
        ovf_reg  <= carry ^ carry_nxt;
`endif
      end
    end
  end

  // Status and result outputs
  always_comb begin
    Busy = (state == ADD);
    Done = (state == DONE);
    S    = s_reg;
    Cout = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
    Ovf  = ovf_reg;
`endif
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8) with hand-computed expectations.
// Define SERIAL_ADDER_OVF_EN to also exercise the Ovf output.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] S;
  logic             Cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             Ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .S     (S),
    .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Present operands with Start for one edge (edge k), then drop Start
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    A = a; B = b; Cin = c; Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    tick(2);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_s",    32'(S),    32'h00);
    check("rst_cout", 32'(Cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf",  32'(Ovf),  32'd0);
`endif
    Reset = 1'b0;
    tick(1);

    // FF + 01: Busy for 8 cycles, Done for 1, S=00 Cout=1
    launch(8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("t1_busy", 32'(Busy), 32'd1);
      check("t1_ndone", 32'(Done), 32'd0);
      if (i < 7) tick(1);
    end
    tick(1);
    check("t1_done", 32'(Done), 32'd1);
    check("t1_nbusy", 32'(Busy), 32'd0);
    check("t1_s",    32'(S),    32'h00);
    check("t1_cout", 32'(Cout), 32'd1);
    A = 8'h55; B = 8'h66;
    tick(1);
    check("t1_done_fall", 32'(Done), 32'd0);
    check("t1_idle_busy", 32'(Busy), 32'd0);
    tick(3);
    check("t1_hold_s",    32'(S),    32'h00);
    check("t1_hold_cout", 32'(Cout), 32'd1);

    // A5 + 5A + 1 = 0x100, then back-to-back 03 + 04
    launch(8'hA5, 8'h5A, 1'b1);
    tick(8);
    check("t2_done", 32'(Done), 32'd1);
    check("t2_s",    32'(S),    32'h00);
    check("t2_cout", 32'(Cout), 32'd1);
    launch(8'h03, 8'h04, 1'b0);
    check("t2_b2b_done", 32'(Done), 32'd0);
    check("t2_b2b_busy", 32'(Busy), 32'd1);
    tick(7);
    check("t2_b2b_predone", 32'(Done), 32'd0);
    tick(1);
    check("t2_b2b_doneb", 32'(Done), 32'd1);
    check("t2_b2b_s",     32'(S),    32'h07);
    check("t2_b2b_cout",  32'(Cout), 32'd0);
    tick(1);

    // 10 + 20 with an ignored Start mid-ADD and operand changes
    launch(8'h10, 8'h20, 1'b0);
    tick(2);
    launch(8'hFF, 8'hFF, 1'b1);
    A = 8'h00; B = 8'hAA; Cin = 1'b1;
    check("t3_busy", 32'(Busy), 32'd1);
    tick(4);
    check("t3_predone", 32'(Done), 32'd0);
    tick(1);
    check("t3_done", 32'(Done), 32'd1);
    check("t3_s",    32'(S),    32'h30);
    check("t3_cout", 32'(Cout), 32'd0);
    tick(1);

    // Reset mid-ADD clears everything; no Done pulse follows
    launch(8'h12, 8'h34, 1'b0);
    tick(3);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    check("t4_busy", 32'(Busy), 32'd0);
    check("t4_done", 32'(Done), 32'd0);
    check("t4_s",    32'(S),    32'h00);
    check("t4_cout", 32'(Cout), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("t4_no_done", 32'(Done), 32'd0);
      tick(1);
    end

    // Reset wins over Start at the same edge
    Reset = 1'b1;
    launch(8'h01, 8'h01, 1'b0);
    Reset = 1'b0;
    check("t5_rst_prio", 32'(Busy), 32'd0);

    // First Start after reset: C8 + 64 + 1 = 0x12D
    launch(8'hC8, 8'h64, 1'b1);
    check("t5_busy", 32'(Busy), 32'd1);
    tick(8);
    check("t5_done", 32'(Done), 32'd1);
    check("t5_s",    32'(S),    32'h2D);
    check("t5_cout", 32'(Cout), 32'd1);
    tick(1);

    // Carry-in only: 00 + 00 + 1
    launch(8'h00, 8'h00, 1'b1);
    tick(8);
    check("t6_s",    32'(S),    32'h01);
    check("t6_cout", 32'(Cout), 32'd0);
    tick(1);

`ifdef SERIAL_ADDER_OVF_EN
    launch(8'h7F, 8'h01, 1'b0);
    tick(8);
    check("ovf1_s",    32'(S),    32'h80);
    check("ovf1_cout", 32'(Cout), 32'd0);
    check("ovf1_ovf",  32'(Ovf),  32'd1);
    tick(2);
    check("ovf1_hold", 32'(Ovf),  32'd1);

    launch(8'h80, 8'h80, 1'b0);
    tick(8);
    check("ovf2_s",    32'(S),    32'h00);
    check("ovf2_cout", 32'(Cout), 32'd1);
    check("ovf2_ovf",  32'(Ovf),  32'd1);
    tick(1);

    launch(8'hFF, 8'h01, 1'b0);
    tick(8);
    check("ovf3_ovf",  32'(Ovf),  32'd0);
    tick(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
